// File: rtl/cache_controller_if.sv
// CPU-side request port and memory-side bus of the cache controller.
// The slave modport belongs to the controller. The master modport belongs
// to the side that issues CPU requests and returns memory read data.
interface cache_controller_if;
  logic       cpu_req;
  logic       cpu_wren;
  logic [4:0] cpu_address;
  logic [7:0] cpu_data;
  logic [7:0] cpu_q;
  logic       cpu_ready;
  logic       busy;
  logic [4:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_wren;
  logic [7:0] mem_q;

  modport slave (
    input  cpu_req, cpu_wren, cpu_address, cpu_data, mem_q,
    output cpu_q, cpu_ready, busy, mem_address, mem_data, mem_wren
  );

  modport master (
    output cpu_req, cpu_wren, cpu_address, cpu_data, mem_q,
    input  cpu_q, cpu_ready, busy, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache with 4 one-byte lines.
// It sits in front of a 32x8 synchronous memory. The memory samples the
// address on posedge, returns q after that edge, and writes on negedge.
// Line index is address[1:0] and line tag is address[4:2].
// Optional feature: define CACHE_STATS_EN to add the saturating
// hit_count/miss_count ports.
// All outputs are registered. cpu_ready rises on the closing edge of
// RESPOND, so it is high during the IDLE cycle that follows.
module cache_controller (
  input  logic              clock,
  input  logic              reset,
  cache_controller_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITEBACK, FILL_ADDR, FILL_WAIT, RESPOND
  } state_t;

  state_t          state;
  logic [3:0]      valid, dirty;
  logic [3:0][2:0] line_tag;
  logic [3:0][7:0] line_data;

  logic            req_wren;
  logic [4:0]      req_addr;
  logic [7:0]      req_data;

  logic [1:0]      idx;
  logic [2:0]      tag;
  logic            hit;

  assign idx = req_addr[1:0];
  assign tag = req_addr[4:2];
  assign hit = valid[idx] && (line_tag[idx] == tag);

  // Controller FSM, line storage and registered bus outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      valid           <= '0;
      dirty           <= '0;
      line_tag        <= '0;
      line_data       <= '0;
      req_wren        <= 1'b0;
      req_addr        <= '0;
      req_data        <= '0;
      bus.cpu_q       <= '0;
      bus.cpu_ready   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_data    <= '0;
      bus.mem_wren    <= 1'b0;
`ifdef CACHE_STATS_EN
      hit_count       <= '0;
      miss_count      <= '0;
`endif
    end else begin
      // Both strobes are single-cycle pulses by default.
      bus.cpu_ready <= 1'b0;
      bus.mem_wren  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            req_wren <= bus.cpu_wren;
            req_addr <= bus.cpu_address;
            req_data <= bus.cpu_data;
            bus.busy <= 1'b1;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
`ifdef CACHE_STATS_EN
          if (hit) begin
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
          end else begin
            if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
          end
`endif
          if (hit) begin
            state <= RESPOND;
          end else if (valid[idx] && dirty[idx]) begin
            // Present the victim now so memory commits it on WRITEBACK's negedge.
            bus.mem_address <= {line_tag[idx], idx};
            bus.mem_data    <= line_data[idx];
            bus.mem_wren    <= 1'b1;
            state           <= WRITEBACK;
          end else if (!req_wren) begin
            bus.mem_address <= req_addr;
            state           <= FILL_ADDR;
          end else begin
            // A write miss overwrites the whole one-byte line, so no fetch is needed.
            state <= RESPOND;
          end
        end
        WRITEBACK: begin
          dirty[idx] <= 1'b0;
          if (req_wren) begin
            state <= RESPOND;
          end else begin
            bus.mem_address <= req_addr;
            state           <= FILL_ADDR;
          end
        end
        FILL_ADDR: state <= FILL_WAIT;
        FILL_WAIT: begin
          line_data[idx] <= bus.mem_q;
          line_tag[idx]  <= tag;
          valid[idx]     <= 1'b1;
          dirty[idx]     <= 1'b0;
          state          <= RESPOND;
        end
        RESPOND: begin
          bus.cpu_ready <= 1'b1;
          bus.busy      <= 1'b0;
          if (req_wren) begin
            line_data[idx] <= req_data;
            line_tag[idx]  <= tag;
            valid[idx]     <= 1'b1;
            dirty[idx]     <= 1'b1;
          end else begin
            bus.cpu_q <= line_data[idx];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural memory and a
// transaction-level cache model. A compare process checks the DUT
// against the model on every negedge.
module tb_cache_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cache_controller_if bus ();
`ifdef CACHE_STATS_EN
  logic [7:0] hit_count, miss_count;
`endif

  cache_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // 32x8 synchronous memory: registered read on posedge, write on negedge.
  logic [7:0] mem [32];
  logic [7:0] mq = '0;
  always @(posedge clock) mq <= mem[bus.mem_address];
  always @(negedge clock) if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
  assign bus.mem_q = mq;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level cache model and a model copy of memory.
  bit         m_valid [4];
  bit         m_dirty [4];
  logic [2:0] m_tag   [4];
  logic [7:0] m_data  [4];
  logic [7:0] mm      [32];
  int         m_hits, m_misses;

  // Expectations for the request in flight.
  bit         active = 0, in_reset = 1;
  int         cyc = 0, t0 = 0;
  int         e_L, e_fk;
  bit         e_wb, e_fill, e_w;
  logic [4:0] e_addr, e_vaddr, e_bus_addr;
  logic [7:0] e_vdata, e_rdata;
  int         ready_k;
  logic [7:0] last_q;
  int         k;
  bit         exp_wren;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic model_start(input bit w, input logic [4:0] a, input logic [7:0] d);
    logic [1:0] ix;
    logic [2:0] tg;
    bit         h;
    ix      = a[1:0];
    tg      = a[4:2];
    h       = m_valid[ix] && m_tag[ix] == tg;
    e_w     = w;
    e_addr  = a;
    e_wb    = !h && m_valid[ix] && m_dirty[ix];
    e_vaddr = {m_tag[ix], ix};
    e_vdata = m_data[ix];
    e_fill  = !h && !w;
    e_fk    = e_wb ? 2 : 1;
    // Compare+respond, plus one cycle for a writeback and two for a fill.
    e_L     = 2 + (e_wb ? 1 : 0) + (e_fill ? 2 : 0);
    if (e_wb) mm[e_vaddr] = e_vdata;
    if (w) begin
      m_data[ix]  = d;
      m_dirty[ix] = 1;
    end else if (!h) begin
      m_data[ix]  = mm[a];
      m_dirty[ix] = 0;
    end
    m_valid[ix] = 1;
    m_tag[ix]   = tg;
    e_rdata     = m_data[ix];
    if (h) begin
      if (m_hits < 255) m_hits++;
    end else begin
      if (m_misses < 255) m_misses++;
    end
  endtask

  task automatic issue(input bit w, input logic [4:0] a, input logic [7:0] d);
    model_start(w, a, d);
    bus.cpu_req     = 1'b1;
    bus.cpu_wren    = w;
    bus.cpu_address = a;
    bus.cpu_data    = d;
    @(posedge clock);
    #1;
    t0          = cyc;
    active      = 1;
    bus.cpu_req = 1'b0;
  endtask

  // One full request. It is called at negedge+1 and returns at negedge+1
  // of the cycle where cpu_ready is expected.
  task automatic req(input bit w, input logic [4:0] a, input logic [7:0] d);
    issue(w, a, d);
    repeat (e_L) @(posedge clock);
    @(negedge clock);
    #1;
    active = 0;
  endtask

  // Compare process: checks the DUT against the model every cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (in_reset) begin
        e_bus_addr = '0;
      end else begin
        exp_wren = 0;
        if (active) begin
          k = cyc - t0;
          if (k == 0) ready_k = -1;
          if (e_wb && k == 1) begin
            e_bus_addr = e_vaddr;
            exp_wren   = 1;
            chk("wb_data", 32'(bus.mem_data), 32'(e_vdata));
          end
          if (e_fill && k == e_fk) e_bus_addr = e_addr;
          chk("busy", 32'(bus.busy), 32'(k < e_L));
          chk("cpu_ready", 32'(bus.cpu_ready), 32'(k == e_L));
          if (bus.cpu_ready) begin
            ready_k = k;
            last_q  = bus.cpu_q;
          end
          if (k == e_L && !e_w) chk("cpu_q", 32'(bus.cpu_q), 32'(e_rdata));
`ifdef CACHE_STATS_EN
          if (k == e_L) begin
            chk("hit_count", 32'(hit_count), 32'(m_hits));
            chk("miss_count", 32'(miss_count), 32'(m_misses));
          end
`endif
        end else begin
          chk("idle_busy", 32'(bus.busy), 32'd0);
          chk("idle_ready", 32'(bus.cpu_ready), 32'd0);
        end
        chk("mem_wren", 32'(bus.mem_wren), 32'(exp_wren));
        chk("mem_address", 32'(bus.mem_address), 32'(e_bus_addr));
      end
    end
  end

  task automatic check_zero_outputs(input string tagname);
    chk({tagname, "_cpu_q"}, 32'(bus.cpu_q), 32'd0);
    chk({tagname, "_ready"}, 32'(bus.cpu_ready), 32'd0);
    chk({tagname, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tagname, "_mem_addr"}, 32'(bus.mem_address), 32'd0);
    chk({tagname, "_mem_data"}, 32'(bus.mem_data), 32'd0);
    chk({tagname, "_mem_wren"}, 32'(bus.mem_wren), 32'd0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  initial begin
    bus.cpu_req     = 1'b0;
    bus.cpu_wren    = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_data    = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 8'(8'hA0 + i);
      mm[i]  = 8'(8'hA0 + i);
    end
    clear_model();

    #2 reset = 1'b1;
    #1 check_zero_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
    #1 in_reset = 0;

    // Clean read miss, then a hit on the same address.
    req(0, 5'h05, 8'h00);
    chk("lit_rd05_q", 32'(last_q), 32'hA5);
    chk("lit_rd05_lat", 32'(ready_k), 32'd4);
    req(0, 5'h05, 8'h00);
    chk("lit_rd05_hit_q", 32'(last_q), 32'hA5);
    chk("lit_rd05_hit_lat", 32'(ready_k), 32'd2);

    // Clean write miss, then a read hit of the written byte.
    req(1, 5'h09, 8'h3C);
    chk("lit_wr09_lat", 32'(ready_k), 32'd2);
    req(0, 5'h09, 8'h00);
    chk("lit_rd09_q", 32'(last_q), 32'h3C);

    // Dirty read miss evicts 0x09 back to memory.
    req(0, 5'h0D, 8'h00);
    chk("lit_rd0d_q", 32'(last_q), 32'hAD);
    chk("lit_rd0d_lat", 32'(ready_k), 32'd5);
    chk("lit_mem09", 32'(mem[9]), 32'h3C);

    // Clean write miss, dirty write miss, then a dirty read miss that
    // fetches the byte written back earlier.
    req(1, 5'h11, 8'h55);
    req(1, 5'h15, 8'h66);
    chk("lit_wr15_lat", 32'(ready_k), 32'd3);
    chk("lit_mem11", 32'(mem[5'h11]), 32'h55);
    req(0, 5'h11, 8'h00);
    chk("lit_rd11_q", 32'(last_q), 32'h55);
    chk("lit_mem15", 32'(mem[5'h15]), 32'h66);
    req(1, 5'h11, 8'h77);
    req(0, 5'h11, 8'h00);
    chk("lit_rd11_hit_q", 32'(last_q), 32'h77);

    // Reset asserted while a clean read miss sits in FILL_WAIT.
    issue(0, 5'h02, 8'h00);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    reset    = 1'b1;
    in_reset = 1;
    active   = 0;
    #1 check_zero_outputs("midreset");
    @(negedge clock);
    reset = 1'b0;
    #1;
    clear_model();
    in_reset = 0;
    repeat (3) @(negedge clock);
    #1;

    // After reset the cache is cold again.
    req(0, 5'h05, 8'h00);
    chk("lit_post_rd05_q", 32'(last_q), 32'hA5);
    chk("lit_post_rd05_lat", 32'(ready_k), 32'd4);
    req(0, 5'h05, 8'h00);
    req(0, 5'h0D, 8'h00);
    chk("lit_post_rd0d_q", 32'(last_q), 32'hAD);
`ifdef CACHE_STATS_EN
    chk("lit_hits", 32'(hit_count), 32'd1);
    chk("lit_misses", 32'(miss_count), 32'd2);
    for (int i = 0; i < 300; i++) req(0, (i % 2 == 0) ? 5'h02 : 5'h06, 8'h00);
    chk("lit_miss_sat", 32'(miss_count), 32'hFF);
    chk("lit_hits_after", 32'(hit_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
